// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths,
// the access-owner encoding and the width of the starvation counter.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
  localparam int WAIT_W      = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the pipeline port, the debug port and the memory pins that
// meet at the data-memory arbiter. The arbiter uses the slave view; the
// requesters plus the memory instance together form the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W
);

  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_dout,
    output p_rdata, p_stall,
    output d_gnt, d_rvalid, d_rdata,
    output mem_we, mem_addr, mem_din
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_dout,
    input  p_rdata, p_stall,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the debug requester has lost
// arbitration. sat_flag tells the arbiter to force the debug access.
module arb_wait_counter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  output logic [WAIT_W-1:0] count,
  output logic              sat_flag
);

  localparam logic [WAIT_W-1:0] SAT_VAL = WAIT_W'(MAX_WAIT);

  assign sat_flag = (count == SAT_VAL);

  // Clear wins over increment; once saturated the count stays put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !sat_flag) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (P)
// and the debug/loader port (D). P has fixed priority, but D is forced
// through after MAX_WAIT lost cycles, stalling P for exactly one cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  logic              sat_flag;
  logic              force_d;
  logic              grant_d;
  logic              grant_p;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_pend;
  owner_t            owner;
  owner_t            owner_next;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] din_hold;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (grant_d | ~bus.d_req),
    .inc      (bus.d_req & ~grant_d),
    .count    (wait_cnt),
    .sat_flag (sat_flag)
  );

  // Same-cycle grant decision and owner for this cycle; nothing is granted in reset.
  always_comb begin
    force_d    = bus.d_req & sat_flag;
    grant_d    = rst_n & bus.d_req & (~bus.p_req | force_d);
    grant_p    = rst_n & bus.p_req & ~grant_d;
    owner_next = OWN_NONE;
    if (grant_d) begin
      owner_next = OWN_D;
    end else if (grant_p) begin
      owner_next = OWN_P;
    end
  end

  // Memory pin mux: the winner drives the pins, otherwise address/data hold and no write.
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = addr_hold;
    bus.mem_din  = din_hold;
    if (grant_d) begin
      bus.mem_we   = bus.d_we;
      bus.mem_addr = bus.d_addr;
      bus.mem_din  = bus.d_wdata;
    end else if (grant_p) begin
      bus.mem_we   = bus.p_we;
      bus.mem_addr = bus.p_addr;
      bus.mem_din  = bus.p_wdata;
    end
  end

  assign bus.d_gnt    = grant_d;
  assign bus.p_stall  = bus.p_req & grant_d;
  assign bus.d_rvalid = rd_pend & rst_n;
  assign bus.d_rdata  = bus.mem_dout;
  assign bus.p_rdata  = bus.mem_dout;

  // Registers the pending debug read, the last driven pins and the access owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend   <= 1'b0;
      addr_hold <= '0;
      din_hold  <= '0;
      owner     <= OWN_NONE;
    end else begin
      rd_pend <= grant_d & ~bus.d_we;
      owner   <= owner_next;
      if (grant_d || grant_p) begin
        addr_hold <= bus.mem_addr;
        din_hold  <= bus.mem_din;
      end
    end
  end

  ap_rvalid_owner : assert property (@(posedge clk) disable iff (!rst_n)
    bus.d_rvalid |-> (owner == OWN_D));

  ap_wait_bound : assert property (@(posedge clk) disable iff (!rst_n)
    int'(wait_cnt) <= MAX_WAIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_WAIT=4 and MAX_WAIT=255) share
// one directed stimulus stream. A behavioural model checks every output of
// both instances each cycle; literal checks pin the key cycle numbers.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we, d_req, d_we;
  logic [6:0]  p_addr, d_addr;
  logic [31:0] p_wdata, d_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus4 ();
  dmem_arbiter_if bus255 ();

  dmem_arbiter #(.MAX_WAIT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  dmem_arbiter #(.MAX_WAIT(255)) dut255 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus255)
  );

  assign bus4.p_req     = p_req;
  assign bus4.p_we      = p_we;
  assign bus4.p_addr    = p_addr;
  assign bus4.p_wdata   = p_wdata;
  assign bus4.d_req     = d_req;
  assign bus4.d_we      = d_we;
  assign bus4.d_addr    = d_addr;
  assign bus4.d_wdata   = d_wdata;
  assign bus255.p_req   = p_req;
  assign bus255.p_we    = p_we;
  assign bus255.p_addr  = p_addr;
  assign bus255.p_wdata = p_wdata;
  assign bus255.d_req   = d_req;
  assign bus255.d_we    = d_we;
  assign bus255.d_addr  = d_addr;
  assign bus255.d_wdata = d_wdata;

  // Read-first synchronous memories, one per instance.
  logic [31:0] ram4   [128] = '{default: '0};
  logic [31:0] ram255 [128] = '{default: '0};

  always @(posedge clk) begin
    if (bus4.mem_we) ram4[bus4.mem_addr] <= bus4.mem_din;
    bus4.mem_dout <= ram4[bus4.mem_addr];
  end

  always @(posedge clk) begin
    if (bus255.mem_we) ram255[bus255.mem_addr] <= bus255.mem_din;
    bus255.mem_dout <= ram255[bus255.mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic pr, input logic pw,
                               input logic [6:0] pa, input logic [31:0] pd,
                               input logic dr, input logic dw,
                               input logic [6:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst_n = rn; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
  endtask

  // Behavioural model state, index 0 = MAX_WAIT 4, index 1 = MAX_WAIT 255.
  int          lost  [2] = '{0, 0};
  bit          pend  [2] = '{0, 0};
  bit          pload [2] = '{0, 0};
  logic [31:0] dexp  [2] = '{0, 0};
  logic [31:0] pexp  [2] = '{0, 0};
  logic [6:0]  laddr [2] = '{0, 0};
  logic [31:0] ldin  [2] = '{0, 0};
  logic [31:0] mm    [2][128] = '{default: '0};

  initial begin : model_check
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int          mw;
        logic        egnt, egp, ewe, erv;
        logic [6:0]  eaddr;
        logic [31:0] edin;
        logic        g_gnt, g_stall, g_we, g_rv;
        logic [6:0]  g_addr;
        logic [31:0] g_din, g_drd, g_prd;
        mw = (k == 0) ? 4 : 255;
        if (k == 0) begin
          g_gnt = bus4.d_gnt; g_stall = bus4.p_stall; g_we = bus4.mem_we; g_rv = bus4.d_rvalid;
          g_addr = bus4.mem_addr; g_din = bus4.mem_din; g_drd = bus4.d_rdata; g_prd = bus4.p_rdata;
        end else begin
          g_gnt = bus255.d_gnt; g_stall = bus255.p_stall; g_we = bus255.mem_we; g_rv = bus255.d_rvalid;
          g_addr = bus255.mem_addr; g_din = bus255.mem_din; g_drd = bus255.d_rdata; g_prd = bus255.p_rdata;
        end
        egnt  = rst_n && d_req && (!p_req || lost[k] == mw);
        egp   = rst_n && p_req && !egnt;
        ewe   = egnt ? d_we : (egp ? p_we : 1'b0);
        eaddr = egnt ? d_addr : (egp ? p_addr : laddr[k]);
        edin  = egnt ? d_wdata : (egp ? p_wdata : ldin[k]);
        erv   = rst_n && pend[k];
        checkOutput($sformatf("d_gnt/mw%0d", mw),    32'(g_gnt),   32'(egnt));
        checkOutput($sformatf("p_stall/mw%0d", mw),  32'(g_stall), 32'(p_req && egnt));
        checkOutput($sformatf("mem_we/mw%0d", mw),   32'(g_we),    32'(ewe));
        checkOutput($sformatf("mem_addr/mw%0d", mw), 32'(g_addr),  32'(eaddr));
        checkOutput($sformatf("mem_din/mw%0d", mw),  g_din,        edin);
        checkOutput($sformatf("d_rvalid/mw%0d", mw), 32'(g_rv),    32'(erv));
        if (erv) checkOutput($sformatf("d_rdata/mw%0d", mw), g_drd, dexp[k]);
        if (pload[k]) checkOutput($sformatf("p_rdata/mw%0d", mw), g_prd, pexp[k]);
        if (!rst_n) begin
          lost[k] = 0; pend[k] = 0; pload[k] = 0; laddr[k] = '0; ldin[k] = '0;
        end else begin
          pend[k]  = egnt && !d_we;
          pload[k] = egp && !p_we;
          if (egnt && !d_we) dexp[k] = mm[k][eaddr];
          if (egp && !p_we)  pexp[k] = mm[k][eaddr];
          if (ewe) mm[k][eaddr] = edin;
          if (egnt || egp) begin
            laddr[k] = eaddr;
            ldin[k]  = edin;
          end
          lost[k] = (egnt || !d_req) ? 0 : ((lost[k] < mw) ? lost[k] + 1 : mw);
        end
      end
    end
  end

  initial begin : stimulus
    int first255;
    rst_n = 1'b0; p_req = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset held with both requesters asking.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h00, 32'h0);
      checkOutput("reset_mem_we", 32'(bus4.mem_we),   32'd0);
      checkOutput("reset_d_gnt",  32'(bus4.d_gnt),    32'd0);
      checkOutput("reset_stall",  32'(bus4.p_stall),  32'd0);
      checkOutput("reset_rvalid", 32'(bus4.d_rvalid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("idle_mem_addr", 32'(bus4.mem_addr), 32'd0);
    checkOutput("idle_mem_din",  bus4.mem_din,       32'd0);

    // Pipeline store then load.
    applyStimulus(1'b1, 1'b1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("p_store_we", 32'(bus4.mem_we), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("p_load_we", 32'(bus4.mem_we), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("p_load_data", bus4.p_rdata, 32'hDEADBEEF);
    checkOutput("p_only_stall", 32'(bus4.p_stall), 32'd0);

    // Debug write then read.
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b1, 7'h7F, 32'h12345678);
    checkOutput("d_write_gnt", 32'(bus4.d_gnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h7F, 32'h0);
    checkOutput("d_read_gnt", 32'(bus4.d_gnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("d_rvalid_pulse", 32'(bus4.d_rvalid), 32'd1);
    checkOutput("d_read_data", bus4.d_rdata, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("d_rvalid_end", 32'(bus4.d_rvalid), 32'd0);

    // Contention: both held; MAX_WAIT=4 grants D at cycles 4 and 9.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 7'(c), 32'h0, 1'b1, 1'b0, 7'h10, 32'h0);
      checkOutput($sformatf("cont_gnt_c%0d", c),    32'(bus4.d_gnt),    32'(c == 4 || c == 9));
      checkOutput($sformatf("cont_stall_c%0d", c),  32'(bus4.p_stall),  32'(c == 4 || c == 9));
      checkOutput($sformatf("cont_rvalid_c%0d", c), 32'(bus4.d_rvalid), 32'(c == 5 || c == 10));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);

    // Saturation: MAX_WAIT=255 instance must grant D at cycle 255.
    first255 = -1;
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 7'(c), 32'h0, 1'b1, 1'b0, 7'h7F, 32'h0);
      if (bus255.d_gnt && first255 < 0) first255 = c;
      if (c == 256) checkOutput("sat_rdata", bus255.d_rdata, 32'h12345678);
    end
    checkOutput("sat_grant_cycle", 32'(first255), 32'd255);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);

    // Reset arrives the cycle after a debug read grant.
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h7F, 32'h0);
    checkOutput("midrd_gnt", 32'(bus4.d_gnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("midrd_rvalid_rst", 32'(bus4.d_rvalid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("midrd_rvalid_after", 32'(bus4.d_rvalid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0);
    checkOutput("midrd_rvalid_late", 32'(bus4.d_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
